// File: rtl/mem_pkg.sv
// Shared definitions for the load/store bus responders: funct3 codes and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: write enables, replicated store
// word, extended load data and access-error detection. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        is_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane selection from the addressed word.
  always_comb begin
    rshift = rword >> {addr_lo, 3'b000};
    rbyte  = rshift[7:0];
    rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Decode size/sign from funct3, then squash enables and data on errors.
  always_comb begin
    byte_en    = 4'b0000;
    wword      = wdata;
    load_data  = 32'h0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wword     = {4{wdata[7:0]}};
        load_data = {{24{rbyte[7]}}, rbyte};
      end
      F3_BU: begin
        illegal   = is_write;
        load_data = {24'h0, rbyte};
      end
      F3_H: begin
        misaligned = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword      = {2{wdata[15:0]}};
        load_data  = {{16{rhalf[15]}}, rhalf};
      end
      F3_HU: begin
        illegal    = is_write;
        misaligned = addr_lo[0];
        load_data  = {16'h0, rhalf};
      end
      F3_W: begin
        misaligned = |addr_lo;
        byte_en    = 4'b1111;
        load_data  = rword;
      end
      default: illegal = 1'b1;
    endcase
    if (!is_write || illegal || misaligned) byte_en = 4'b0000;
    if (is_write || illegal || misaligned) load_data = 32'h0;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Data-memory responder: one request at a time, array access on the accept
// edge, response after WAIT_STATES extra cycles.
module mem_bus_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = "",
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH_WORDS];

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_err_q, pend_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic [AW-1:0] idx;
  logic [31:0]   rword, wword, load_data;
  logic [3:0]    byte_en;
  logic          misaligned, illegal, accept, acc_err;

  assign idx     = req_addr[AW+1:2];
  assign rword   = mem[idx];
  assign accept  = req_valid & rdy_q;
  assign acc_err = misaligned | illegal;

  mem_lane_align u_align (
    .is_write  (req_write),
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wword     (wword),
    .load_data (load_data),
    .misaligned(misaligned),
    .illegal   (illegal)
  );

  // Next state, wait counter, ready and response staging.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_data_d = pend_data_q;
    pend_err_d  = pend_err_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (accept) begin
        pend_data_d = load_data;
        pend_err_d  = acc_err;
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end else begin
          state_d = RESP;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs change only on entry to RESP; with no wait states that entry
    // is the accept edge itself, so the live lane result is used.
    if (state_d == RESP && state_q != RESP) begin
      rsp_data_d = (state_q == IDLE) ? load_data : pend_data_q;
      rsp_err_d  = (state_q == IDLE) ? acc_err   : pend_err_q;
    end
    rdy_d = (state_d == IDLE);
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rdy_q       <= 1'b0;
      pend_data_q <= 32'h0;
      pend_err_q  <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
      pend_data_q <= pend_data_d;
      pend_err_q  <= pend_err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-enabled array write on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept)
      for (int l = 0; l < NUM_LANES; l++)
        if (byte_en[l]) mem[idx][l] <= wword[LANE_W*l +: LANE_W];
  end

  assign req_ready = rdy_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed + random bench for two responders (0 and 3 wait states) sharing a
// clock/reset, checked against a byte-level memory model.
module tb_mem_bus_responder;

  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0, req_write = '0, req_ready, rsp_valid, rsp_err;
  logic [1:0][2:0]  req_funct3 = '0;
  logic [1:0][31:0] req_addr = '0, req_wdata = '0, rsp_rdata;

  int total = 0, bad = 0;
  int pulses [2] = '{0, 0};
  int exp_pulses [2] = '{0, 0};
  int ws [2] = '{0, 3};
  logic [7:0]  mm [2][DEPTH*4];
  logic [31:0] obs_rd;
  logic        obs_err;

  mem_bus_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE(""), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  mem_bus_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE(""), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rsp_valid[0] === 1'b1) pulses[0]++;
    if (rsp_valid[1] === 1'b1) pulses[1]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size from funct3, wrap on DEPTH.
  function automatic void model(input int s, input bit w, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic er);
    int size, base;
    bit legal;
    logic [31:0] v;
    size  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    er    = !legal || ((a % size) != 0);
    rd    = 32'h0;
    if (er) return;
    base = int'((a / 4) % DEPTH) * 4 + int'(a % 4);
    if (w) begin
      for (int i = 0; i < size; i++) mm[s][base+i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mm[s][base+i];
      if (!f[2] && size < 4 && v[8*size-1])
        for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
      rd = v;
    end
  endfunction

  // One complete transaction; entered and left on a negedge.
  task automatic do_req(input int s, input bit w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] erd;
    logic        eer;
    int n;
    model(s, w, f, a, d, erd, eer);
    n = 0;
    while (req_ready[s] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("ready_before_req", {31'h0, req_ready[s]}, 32'h1);
    req_valid[s] = 1'b1; req_write[s] = w; req_funct3[s] = f;
    req_addr[s] = a; req_wdata[s] = d;
    @(negedge clk);
    req_valid[s] = 1'b0;
    n = 1;
    while (rsp_valid[s] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    exp_pulses[s]++;
    obs_rd = rsp_rdata[s];
    obs_err = rsp_err[s];
    chk("latency", n, ws[s] + 1);
    chk("rdata", obs_rd, erd);
    chk("err", {31'h0, obs_err}, {31'h0, eer});
  endtask

  initial begin
    int first_rsp, low, nxt, n;
    logic [31:0] erd;
    logic        eer;
    logic [31:0] a;
    #1 rst = 1'b0;
    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("rst_ready", {30'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    chk("rst_rdata0", rsp_rdata[0], 32'h0);
    rst = 1'b1;
    chk("ready_at_release", {30'h0, req_ready}, 32'h0);
    @(negedge clk);
    chk("ready_one_edge_after", {30'h0, req_ready}, 32'h3);
    repeat (4) @(negedge clk);
    chk("no_spurious_rsp", pulses[0] + pulses[1], 0);

    for (int i = 0; i < DEPTH; i++) do_req(0, 1'b1, 3'b010, 32'(i*4), $urandom);

    // Sub-word loads from a stored word
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(0, 1'b0, 3'b000, 32'h13, 32'h0); chk("lb_13",  obs_rd, 32'hFFFFFFDE);
    do_req(0, 1'b0, 3'b100, 32'h13, 32'h0); chk("lbu_13", obs_rd, 32'h000000DE);
    do_req(0, 1'b0, 3'b001, 32'h12, 32'h0); chk("lh_12",  obs_rd, 32'hFFFFDEAD);
    do_req(0, 1'b0, 3'b101, 32'h12, 32'h0); chk("lhu_12", obs_rd, 32'h0000DEAD);
    // Partial stores keep untouched lanes
    do_req(0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF55);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0); chk("lw_after_sb", obs_rd, 32'hDEAD55EF);
    do_req(0, 1'b1, 3'b001, 32'h12, 32'hAAAA1234);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0); chk("lw_after_sh", obs_rd, 32'h123455EF);
    // Errors
    do_req(0, 1'b1, 3'b010, 32'h14, 32'h0BADF00D);
    do_req(0, 1'b0, 3'b010, 32'h12, 32'h0); chk("lw_mis_err", {31'h0, obs_err}, 32'h1);
    chk("lw_mis_rdata", obs_rd, 32'h0);
    do_req(0, 1'b0, 3'b001, 32'h11, 32'h0); chk("lh_mis_err", {31'h0, obs_err}, 32'h1);
    do_req(0, 1'b0, 3'b011, 32'h10, 32'h0); chk("f3_011_err", {31'h0, obs_err}, 32'h1);
    chk("f3_011_rdata", obs_rd, 32'h0);
    do_req(0, 1'b1, 3'b100, 32'h14, 32'h12345678); chk("sbu_err", {31'h0, obs_err}, 32'h1);
    do_req(0, 1'b1, 3'b010, 32'h16, 32'hFFFFFFFF); chk("sw_mis_err", {31'h0, obs_err}, 32'h1);
    do_req(0, 1'b0, 3'b010, 32'h14, 32'h0); chk("lw_14_kept", obs_rd, 32'h0BADF00D);

    // Held req_valid with 3 wait states: latency, ready-low span, throughput
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h30; req_wdata[1] = 32'hC0FFEE00;
    model(1, 1'b1, 3'b010, 32'h30, 32'hC0FFEE00, erd, eer);
    model(1, 1'b1, 3'b010, 32'h30, 32'hC0FFEE00, erd, eer);
    first_rsp = 0; low = 0; nxt = 0;
    for (int j = 1; j <= 12 && nxt == 0; j++) begin
      @(negedge clk);
      if (rsp_valid[1] === 1'b1 && first_rsp == 0) first_rsp = j;
      if (req_ready[1] !== 1'b1) low++; else nxt = j;
    end
    chk("ws3_latency", first_rsp, 4);
    chk("ws3_ready_low", low, 4);
    chk("ws3_next_accept", nxt, 5);
    @(negedge clk);
    req_valid[1] = 1'b0;
    n = 1;
    while (rsp_valid[1] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("ws3_second_latency", n, 4);
    exp_pulses[1] += 2;

    // Reset during WAIT: request abandoned, store already committed
    while (req_ready[1] !== 1'b1) @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h20; req_wdata[1] = 32'hA5A5A5A5;
    model(1, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, erd, eer);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst = 1'b0;
    #1 chk("mid_rst_ready", {31'h0, req_ready[1]}, 32'h0);
    chk("mid_rst_rsp_valid", {31'h0, rsp_valid[1]}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'h0, req_ready[1]}, 32'h1);
    chk("post_rst_rdata", rsp_rdata[1], 32'h0);
    repeat (6) @(negedge clk);
    chk("aborted_no_rsp", pulses[1], exp_pulses[1]);
    do_req(1, 1'b0, 3'b010, 32'h20, 32'h0); chk("lw_20_after_rst", obs_rd, 32'hA5A5A5A5);

    for (int i = 0; i < DEPTH; i++)
      if (i != 8) do_req(1, 1'b1, 3'b010, 32'(i*4), $urandom);

    // Random traffic with wrapping addresses
    for (int k = 0; k < 160; k++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_req(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    for (int k = 0; k < 50; k++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_req(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    repeat (3) @(negedge clk);
    chk("pulse_count0", pulses[0], exp_pulses[0]);
    chk("pulse_count1", pulses[1], exp_pulses[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
